// File: rtl/tank_pkg.sv
// Shared types and geometry for the tank damage controller.
package tank_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_BOOM      = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } tank_state_t;

  localparam int TANK_SIZE   = 32;
  localparam int BULLET_SIZE = 4;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

endpackage

// File: rtl/box_overlap.sv
// Combinational bounding-box test between the tank square and one enemy bullet.
module box_overlap
  import tank_pkg::*;
(
  input  logic       active,
  input  logic [9:0] x_tank,
  input  logic [9:0] y_tank,
  input  logic [9:0] x_bullet,
  input  logic [9:0] y_bullet,
  output logic       hit
);

  localparam logic [10:0] TANK_EXT   = 11'(TANK_SIZE - 1);
  localparam logic [10:0] BULLET_EXT = 11'(BULLET_SIZE - 1);

  logic [10:0] xt, yt, xb, yb;

  // 11-bit operands so edges near the right/bottom of the 10-bit range cannot wrap
  assign xt = {1'b0, x_tank};
  assign yt = {1'b0, y_tank};
  assign xb = {1'b0, x_bullet};
  assign yb = {1'b0, y_bullet};

  assign hit = active
             && (xb <= xt + TANK_EXT) && (xb + BULLET_EXT >= xt)
             && (yb <= yt + TANK_EXT) && (yb + BULLET_EXT >= yt);

endmodule

// File: rtl/tank_damage_ctrl.sv
// Player tank hit/explosion/respawn/lives controller, advanced on refresh_tick.
// Optional post-respawn immunity is built when TANK_INVULN_EN is defined.
//
//   state        | meaning
//   ST_ALIVE     | tank drivable, bullets checked for overlap
//   ST_BOOM      | explosion shown for BOOM_TICKS ticks
//   ST_RESPAWN   | one tick: pulse respawn, arm immunity
//   ST_GAME_OVER | no lives left, sticky until reset
module tank_damage_ctrl
  import tank_pkg::*;
#(
  parameter int NUM_ENEMY    = 2,
  parameter int LIVES_INIT   = 3,
  parameter int BOOM_TICKS   = 8,
  parameter int INVULN_TICKS = 120
) (
  input  logic                    clk_50MHz,
  input  logic                    reset,
  input  logic                    refresh_tick,
  input  logic [9:0]              x_tank,
  input  logic [9:0]              y_tank,
  input  logic [NUM_ENEMY*10-1:0] x_bullet,
  input  logic [NUM_ENEMY*10-1:0] y_bullet,
  input  logic [NUM_ENEMY-1:0]    bullet_active,
  output logic [NUM_ENEMY-1:0]    hit_ack,
  output logic                    tank_detroyed,
  output logic [1:0]              lives,
  output logic                    respawn,
  output logic                    invuln,
  output logic                    game_over
);

  localparam int BW = (BOOM_TICKS > 1) ? $clog2(BOOM_TICKS) : 1;
  localparam logic [BW-1:0] BOOM_LAST = BW'(BOOM_TICKS - 1);

  logic [NUM_ENEMY-1:0] overlap;

  for (genvar gi = 0; gi < NUM_ENEMY; gi++) begin : g_enemy
    box_overlap u_box (
      .active   (bullet_active[gi]),
      .x_tank   (x_tank),
      .y_tank   (y_tank),
      .x_bullet (x_bullet[10*gi +: 10]),
      .y_bullet (y_bullet[10*gi +: 10]),
      .hit      (overlap[gi])
    );
  end

  tank_state_t          state, state_nxt;
  logic [BW-1:0]        boom_cnt, boom_cnt_nxt;
  logic [1:0]           lives_nxt;
  logic [NUM_ENEMY-1:0] hit_ack_nxt;
  logic                 respawn_nxt;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state    <= ST_ALIVE;
      boom_cnt <= '0;
      lives    <= 2'(LIVES_INIT);
      hit_ack  <= '0;
      respawn  <= 1'b0;
    end else begin
      state    <= state_nxt;
      boom_cnt <= boom_cnt_nxt;
      lives    <= lives_nxt;
      hit_ack  <= hit_ack_nxt;
      respawn  <= respawn_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    boom_cnt_nxt = boom_cnt;
    lives_nxt    = lives;
    hit_ack_nxt  = '0;
    respawn_nxt  = 1'b0;
    if (refresh_tick) begin
      case (state)
        ST_ALIVE: begin
          // every overlapping bullet is retired, but a volley costs one life
          if (|overlap) begin
            hit_ack_nxt = overlap;
            if (!invuln) begin
              state_nxt    = ST_BOOM;
              boom_cnt_nxt = '0;
              if (lives != 2'd0) lives_nxt = lives - 2'd1;
            end
          end
        end
        ST_BOOM: begin
          if (boom_cnt == BOOM_LAST)
            state_nxt = (lives == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
          else
            boom_cnt_nxt = boom_cnt + 1'b1;
        end
        ST_RESPAWN: begin
          respawn_nxt = 1'b1;
          state_nxt   = ST_ALIVE;
        end
        ST_GAME_OVER: state_nxt = ST_GAME_OVER;
        default:      state_nxt = ST_ALIVE;
      endcase
    end
  end

`ifdef TANK_INVULN_EN
  localparam int IW = $clog2(INVULN_TICKS + 1);
  logic [IW-1:0] invuln_cnt;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset)
      invuln_cnt <= '0;
    else if (refresh_tick) begin
      if (state == ST_RESPAWN)
        invuln_cnt <= IW'(INVULN_TICKS);
      else if (state == ST_ALIVE && invuln_cnt != '0)
        invuln_cnt <= invuln_cnt - 1'b1;
    end
  end

  assign invuln = (invuln_cnt != '0);
`else
  // immunity not built; the parameter stays on the interface and folds to 0
  assign invuln = (INVULN_TICKS < 0);
`endif

  assign tank_detroyed = (state == ST_BOOM) || (state == ST_GAME_OVER);
  assign game_over     = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_tank_damage_ctrl.sv
// Directed bench for tank_damage_ctrl; covers the TANK_INVULN_EN build when defined.
module tb_tank_damage_ctrl;

  logic        clk_50MHz = 1'b0;
  logic        reset = 1'b0;
  logic        refresh_tick = 1'b0;
  logic [9:0]  x_tank = 10'd100;
  logic [9:0]  y_tank = 10'd100;
  logic [19:0] x_bullet = '0;
  logic [19:0] y_bullet = '0;
  logic [1:0]  bullet_active = '0;
  logic [1:0]  hit_ack;
  logic        tank_detroyed;
  logic [1:0]  lives;
  logic        respawn;
  logic        invuln;
  logic        game_over;

  int vectors = 0;
  int miscompares = 0;

  tank_damage_ctrl dut (
    .clk_50MHz     (clk_50MHz),
    .reset         (reset),
    .refresh_tick  (refresh_tick),
    .x_tank        (x_tank),
    .y_tank        (y_tank),
    .x_bullet      (x_bullet),
    .y_bullet      (y_bullet),
    .bullet_active (bullet_active),
    .hit_ack       (hit_ack),
    .tank_detroyed (tank_detroyed),
    .lives         (lives),
    .respawn       (respawn),
    .invuln        (invuln),
    .game_over     (game_over)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // one-clock strobe; returns at the negedge after the evaluating posedge
  task automatic tick();
    @(negedge clk_50MHz);
    refresh_tick = 1'b1;
    @(negedge clk_50MHz);
    refresh_tick = 1'b0;
  endtask

  task automatic set_bullet(input int i, input int x, input int y, input logic act);
    x_bullet[10*i +: 10] = 10'(x);
    y_bullet[10*i +: 10] = 10'(y);
    bullet_active[i]     = act;
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_50MHz);
    reset = 1'b0;
    #1;
    chk("rst_lives", lives, 2'd3);
    chk("rst_hit_ack", hit_ack, 2'b00);
    chk("rst_respawn", {1'b0, respawn}, 2'd0);
    chk("rst_destroyed", {1'b0, tank_detroyed}, 2'd0);
    chk("rst_game_over", {1'b0, game_over}, 2'd0);
    chk("rst_invuln", {1'b0, invuln}, 2'd0);
    @(negedge clk_50MHz);
    reset = 1'b1;
  endtask

  task automatic test_no_overlap();
    set_bullet(0, 132, 120, 1'b1);
    set_bullet(1, 110, 110, 1'b0);
    tick();
    chk("miss_right_ack", hit_ack, 2'b00);
    chk("miss_right_lives", lives, 2'd3);
    set_bullet(0, 110, 110, 1'b0);
    set_bullet(1, 96, 100, 1'b1);
    tick();
    chk("miss_inactive_left_ack", hit_ack, 2'b00);
    chk("miss_destroyed", {1'b0, tank_detroyed}, 2'd0);
    set_bullet(1, 0, 0, 1'b0);
  endtask

  task automatic test_no_tick();
    set_bullet(0, 131, 120, 1'b1);
    repeat (3) @(negedge clk_50MHz);
    chk("no_tick_ack", hit_ack, 2'b00);
    chk("no_tick_lives", lives, 2'd3);
    set_bullet(0, 0, 0, 1'b0);
  endtask

  // runs the remaining BOOM ticks after a hit and expects a respawn pulse
  task automatic run_boom_to_respawn(input string tag);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, "_boom_destroyed"}, {1'b0, tank_detroyed}, (k < 8) ? 2'd1 : 2'd0);
      chk({tag, "_boom_no_respawn"}, {1'b0, respawn}, 2'd0);
    end
    tick();
    chk({tag, "_respawn_pulse"}, {1'b0, respawn}, 2'd1);
    @(negedge clk_50MHz);
    chk({tag, "_respawn_width"}, {1'b0, respawn}, 2'd0);
  endtask

  task automatic wait_invuln_clear();
`ifdef TANK_INVULN_EN
    chk("invuln_set", {1'b0, invuln}, 2'd1);
    repeat (120) tick();
`endif
    chk("invuln_clear", {1'b0, invuln}, 2'd0);
  endtask

  task automatic test_single_hit();
    set_bullet(0, 131, 120, 1'b1);
    tick();
    chk("hit1_ack", hit_ack, 2'b01);
    chk("hit1_lives", lives, 2'd2);
    chk("hit1_destroyed", {1'b0, tank_detroyed}, 2'd1);
    @(negedge clk_50MHz);
    chk("hit1_ack_width", hit_ack, 2'b00);
    set_bullet(0, 0, 0, 1'b0);
    run_boom_to_respawn("hit1");
    wait_invuln_clear();
  endtask

  task automatic test_double_hit();
    set_bullet(0, 131, 120, 1'b1);
    set_bullet(1, 97, 100, 1'b1);
    tick();
    chk("hit2_ack", hit_ack, 2'b11);
    chk("hit2_lives", lives, 2'd1);
    set_bullet(0, 0, 0, 1'b0);
    set_bullet(1, 0, 0, 1'b0);
    run_boom_to_respawn("hit2");
  endtask

  task automatic test_third_hit();
`ifdef TANK_INVULN_EN
    repeat (9) tick();
    chk("inv_armed", {1'b0, invuln}, 2'd1);
    set_bullet(0, 131, 120, 1'b1);
    tick();
    chk("inv10_ack", hit_ack, 2'b01);
    chk("inv10_lives", lives, 2'd1);
    chk("inv10_destroyed", {1'b0, tank_detroyed}, 2'd0);
    set_bullet(0, 0, 0, 1'b0);
    repeat (109) tick();
    set_bullet(0, 131, 120, 1'b1);
    tick();
    chk("inv120_ack", hit_ack, 2'b01);
    chk("inv120_lives", lives, 2'd1);
    chk("inv120_expired", {1'b0, invuln}, 2'd0);
`else
    chk("noinv_flag", {1'b0, invuln}, 2'd0);
`endif
    set_bullet(1, 100, 131, 1'b1);
    set_bullet(0, 0, 0, 1'b0);
    tick();
    chk("hit3_ack", hit_ack, 2'b10);
    chk("hit3_lives", lives, 2'd0);
    chk("hit3_destroyed", {1'b0, tank_detroyed}, 2'd1);
  endtask

  task automatic test_game_over();
    int pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (respawn) pulses++;
    end
    chk("go_flag", {1'b0, game_over}, 2'd1);
    chk("go_destroyed", {1'b0, tank_detroyed}, 2'd1);
    set_bullet(0, 131, 120, 1'b1);
    set_bullet(1, 100, 131, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (respawn) pulses++;
      chk("go_no_ack", hit_ack, 2'b00);
    end
    chk("go_no_respawn", 2'(pulses), 2'd0);
    chk("go_lives_floor", lives, 2'd0);
    chk("go_sticky", {1'b0, game_over}, 2'd1);
    set_bullet(0, 0, 0, 1'b0);
    set_bullet(1, 0, 0, 1'b0);
    test_reset();
    chk("go_reset_destroyed", {1'b0, tank_detroyed}, 2'd0);
    chk("go_reset_lives", lives, 2'd3);
  endtask

  task automatic test_reset_mid_boom();
    int pulses = 0;
    set_bullet(0, 131, 120, 1'b1);
    tick();
    chk("mid_hit_lives", lives, 2'd2);
    set_bullet(0, 0, 0, 1'b0);
    repeat (4) tick();
    chk("mid_destroyed", {1'b0, tank_detroyed}, 2'd1);
    test_reset();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk_50MHz);
      refresh_tick = (k % 2 == 0);
      if (respawn) pulses++;
    end
    refresh_tick = 1'b0;
    chk("mid_no_respawn", 2'(pulses), 2'd0);
    chk("mid_alive", {1'b0, tank_detroyed}, 2'd0);
    chk("mid_lives_after", lives, 2'd3);
  endtask

  initial begin
    test_reset();
    test_no_overlap();
    test_no_tick();
    test_single_hit();
    test_double_hit();
    test_third_hit();
    test_game_over();
    test_reset_mid_boom();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
